// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache types: fill FSM encoding and address-split helpers
package cache_pkg;

    typedef logic [1:0] fill_state_t;

    localparam fill_state_t ST_IDLE = 2'd0;
    localparam fill_state_t ST_FILL = 2'd1;
    localparam fill_state_t ST_DONE = 2'd2;

    // Byte offset within the line: low off_w bits of the address.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int off_w);
        return addr & ((32'd1 << off_w) - 32'd1);
    endfunction

    // Line index: the idx_w bits sitting just above the offset field.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off_w,
                                               input int idx_w);
        return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag: the top tag_w bits of an addr_w-bit address.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int tag_w,
                                             input int addr_w);
        return (addr >> (addr_w - tag_w)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - critical-byte-first line-fill controller for the direct-mapped read cache
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int TAG_WIDTH  = 12,
    parameter int BLOCK_SIZE = 8,
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE),
    localparam int INDEX_WIDTH  = ADDR_WIDTH - TAG_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_rd,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic                    line_hit,
    output logic                    cpu_stall,
    output logic                    crit_valid,
    output logic [7:0]              crit_data,
    output logic                    busy,
    output logic [TAG_WIDTH-1:0]    fill_tag,
    output logic [INDEX_WIDTH-1:0]  fill_index,
    output logic                    fill_tag_en,
    output logic                    fill_en,
    output logic [OFFSET_WIDTH-1:0] fill_off,
    output logic [7:0]              fill_data,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_ack,
    input  logic [7:0]              mem_rdata
);

    if (INDEX_WIDTH < 1 || BLOCK_SIZE < 2 || (BLOCK_SIZE & (BLOCK_SIZE - 1)) != 0 ||
        ADDR_WIDTH > 32) begin : g_bad_cfg
        $error("cache_fill_ctrl: illegal ADDR_WIDTH/TAG_WIDTH/BLOCK_SIZE combination");
    end

    localparam logic [OFFSET_WIDTH-1:0] LAST_CNT = OFFSET_WIDTH'(BLOCK_SIZE - 1);

    fill_state_t             state;
    logic [OFFSET_WIDTH-1:0] start_off;
    logic [OFFSET_WIDTH-1:0] cnt;
    logic [OFFSET_WIDTH-1:0] cur_off;
    logic [OFFSET_WIDTH-1:0] next_off;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_off;
    logic                    miss;
    logic                    ack_fill;
    logic                    first_ack;
    logic                    last_ack;

    assign req_tag   = TAG_WIDTH'(addr_tag(32'(cpu_addr), TAG_WIDTH, ADDR_WIDTH));
    assign req_index = INDEX_WIDTH'(addr_index(32'(cpu_addr), OFFSET_WIDTH, INDEX_WIDTH));
    assign req_off   = OFFSET_WIDTH'(addr_offset(32'(cpu_addr), OFFSET_WIDTH));

    // Wrap-around offset: the narrow width makes the add modulo BLOCK_SIZE.
    assign cur_off   = start_off + cnt;
    assign next_off  = cur_off + OFFSET_WIDTH'(1);

    assign miss      = cpu_rd & ~line_hit;
    assign ack_fill  = (state == ST_FILL) & mem_ack;
    assign first_ack = ack_fill & (cnt == '0);
    assign last_ack  = ack_fill & (cnt == LAST_CNT);

    assign busy        = (state != ST_IDLE);
    assign fill_en     = ack_fill;
    assign fill_off    = ack_fill ? cur_off : '0;
    assign fill_data   = ack_fill ? mem_rdata : 8'h00;
    assign fill_tag_en = last_ack;
    assign crit_valid  = first_ack;
    assign crit_data   = first_ack ? mem_rdata : 8'h00;

    // CPU is released for exactly the cycle its byte is bypassed, otherwise held while filling.
    always_comb begin
        cpu_stall = 1'b1;
        case (state)
            ST_IDLE: cpu_stall = miss;
            ST_FILL: cpu_stall = ~first_ack;
            default: cpu_stall = 1'b1;
        endcase
    end

    // Fill sequencer: latch the miss, walk the line from the critical byte, settle one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            fill_tag   <= '0;
            fill_index <= '0;
            start_off  <= '0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        state      <= ST_FILL;
                        fill_tag   <= req_tag;
                        fill_index <= req_index;
                        start_off  <= req_off;
                        cnt        <= '0;
                        mem_req    <= 1'b1;
                        mem_addr   <= {req_tag, req_index, req_off};
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + OFFSET_WIDTH'(1);
                        if (cnt == LAST_CNT) begin
                            state    <= ST_DONE;
                            mem_req  <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            mem_addr <= {fill_tag, fill_index, next_off};
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - directed self-checking bench for cache_fill_ctrl
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_rd;
    logic [15:0] cpu_addr;
    logic        line_hit;
    logic        cpu_stall;
    logic        crit_valid;
    logic [7:0]  crit_data;
    logic        busy;
    logic [11:0] fill_tag;
    logic [0:0]  fill_index;
    logic        fill_tag_en;
    logic        fill_en;
    logic [2:0]  fill_off;
    logic [7:0]  fill_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    cache_fill_ctrl #(
        .ADDR_WIDTH(16),
        .TAG_WIDTH (12),
        .BLOCK_SIZE(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_rd     (cpu_rd),
        .cpu_addr   (cpu_addr),
        .line_hit   (line_hit),
        .cpu_stall  (cpu_stall),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .busy       (busy),
        .fill_tag   (fill_tag),
        .fill_index (fill_index),
        .fill_tag_en(fill_tag_en),
        .fill_en    (fill_en),
        .fill_off   (fill_off),
        .fill_data  (fill_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: each byte is its low address byte scrambled with a constant.
    assign mem_rdata = mem_addr[7:0] ^ 8'h5A;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_stall"}, {31'd0, cpu_stall}, 0);
        chk({name, "_crit"}, {23'd0, crit_valid, crit_data}, 0);
        chk({name, "_busy"}, {31'd0, busy}, 0);
        chk({name, "_tag"}, {19'd0, fill_index, fill_tag}, 0);
        chk({name, "_fill"}, {19'd0, fill_tag_en, fill_en, fill_off, fill_data}, 0);
        chk({name, "_mem"}, {15'd0, mem_req, mem_addr}, 0);
    endtask

    // One complete fill from the miss cycle through DONE; ack arrives every 'period' FILL cycles.
    task automatic do_fill(input logic [15:0] addr, input int period);
        logic [11:0] tg;
        logic        idx;
        logic [2:0]  so;
        logic [2:0]  off;
        logic [15:0] ea;
        logic        ack;
        int          acks;
        int          cyc;
        tg = addr[15:4];
        idx = addr[3];
        so = addr[2:0];
        @(posedge clk);
        #1;
        cpu_rd = 1'b1;
        cpu_addr = addr;
        line_hit = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("miss_stall", {31'd0, cpu_stall}, 1);
        chk("miss_busy_req", {30'd0, busy, mem_req}, 0);
        acks = 0;
        cyc = 0;
        while (acks < 8 && cyc < 200) begin
            cyc++;
            ack = ((cyc % period) == 0);
            @(posedge clk);
            #1;
            mem_ack = ack;
            cpu_addr = ~addr;
            cpu_rd = cyc[0];
            off = so + acks[2:0];
            ea = {tg, idx, off};
            @(negedge clk);
            chk("fill_busy_req", {30'd0, busy, mem_req}, 3);
            chk("fill_mem_addr", {16'd0, mem_addr}, {16'd0, ea});
            chk("fill_tag_idx", {19'd0, fill_index, fill_tag}, {19'd0, idx, tg});
            chk("fill_en", {31'd0, fill_en}, {31'd0, ack});
            chk("fill_off", {29'd0, fill_off}, ack ? {29'd0, off} : 0);
            chk("fill_data", {24'd0, fill_data}, ack ? {24'd0, ea[7:0] ^ 8'h5A} : 0);
            chk("crit_valid", {31'd0, crit_valid}, {31'd0, ack && acks == 0});
            chk("crit_data", {24'd0, crit_data},
                (ack && acks == 0) ? {24'd0, ea[7:0] ^ 8'h5A} : 0);
            chk("fill_tag_en", {31'd0, fill_tag_en}, {31'd0, ack && acks == 7});
            chk("fill_stall", {31'd0, cpu_stall}, {31'd0, !(ack && acks == 0)});
            if (ack) acks++;
        end
        chk("fill_cycles", cyc, 8 * period);
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        cpu_rd = 1'b1;
        @(negedge clk);
        chk("done_busy_stall", {30'd0, busy, cpu_stall}, 3);
        chk("done_mem", {15'd0, mem_req, mem_addr}, 0);
        chk("done_strobes", {29'd0, fill_en, fill_tag_en, crit_valid}, 0);
    endtask

    // IDLE cycle where the line now hits: nothing fetched, CPU runs.
    task automatic do_hit(input logic [15:0] addr);
        @(posedge clk);
        #1;
        cpu_rd = 1'b1;
        cpu_addr = addr;
        line_hit = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("hit_stall", {31'd0, cpu_stall}, 0);
        chk("hit_busy_req", {30'd0, busy, mem_req}, 0);
        chk("hit_strobes", {29'd0, fill_en, fill_tag_en, crit_valid}, 0);
    endtask

    initial begin
        rst = 1'b1;
        cpu_rd = 1'b0;
        cpu_addr = 16'h0000;
        line_hit = 1'b0;
        mem_ack = 1'b0;
        #2;
        chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("post_rst");

        // Wrap-around fill with zero-wait memory, then the hit on the next cycle.
        do_fill(16'h1235, 1);
        do_hit(16'h1235);

        // Same miss with one ack every third cycle.
        do_fill(16'h1235, 3);
        do_hit(16'h1235);

        // Hit held for another cycle stays quiet.
        do_hit(16'h4567);

        // Aligned miss in index 1, then a back-to-back miss in the first IDLE cycle.
        do_fill(16'h0008, 1);
        do_fill(16'hABC2, 2);
        do_hit(16'hABC2);

        // Reset mid-fill after three acks.
        @(posedge clk);
        #1;
        cpu_rd = 1'b1;
        cpu_addr = 16'h1235;
        line_hit = 1'b0;
        mem_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_mem_addr", {16'd0, mem_addr}, 32'h0000_1230);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_stall", {31'd0, cpu_stall}, 1);
        chk("midrst_busy_req", {30'd0, busy, mem_req}, 0);
        chk("midrst_mem_addr", {16'd0, mem_addr}, 0);
        chk("midrst_strobes", {29'd0, fill_en, fill_tag_en, crit_valid}, 0);
        cpu_rd = 1'b0;
        mem_ack = 1'b0;
        #1;
        rst = 1'b0;
        do_fill(16'h1235, 1);
        do_hit(16'h1235);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
